branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Execute-stage counterpart of the 2-bit saturating-counter branch predictor. The predictor supplies direction predictions at fetch. This block does three things:
- Holds each prediction and its two candidate targets in a small in-order queue until the branch reaches EX.
- Evaluates the real branch condition from the register operands.
- Drives the predictor's training inputs (update, actual decision) and issues the mispredict flush and redirect PC to fetch.

It also keeps saturating branch and mispredict statistics counters.

## Interface
- XLEN, 32, operand and address width
- DEPTH, 2, in-flight branch queue entries (power of two, ≥2)
- CNT_W, 16, statistics counter width

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  pipeline stall; while high, push_i and resolve_i are ignored and no state changes except the counters' hold
- push_i  in  1  fetch issued a conditional branch this cycle
- pred_i  in  1  predicted direction for the pushed branch (1 = taken)
- tgt_taken_i  in  XLEN  branch target for the pushed branch
- tgt_ntaken_i  in  XLEN  fall-through PC (PC+4) for the pushed branch
- resolve_i  in  1  oldest in-flight branch is in EX this cycle
- funct3_i  in  3  branch type of the resolving branch
- rs1_i, rs2_i  in  XLEN  resolving branch operands
- update_o  out  1  registered; predictor train strobe
- decision_o  out  1  registered; actual direction
- mispredict_o  out  1  registered; flush younger stages
- redirect_o  out  XLEN  registered; correct next PC, valid when mispredict_o=1
- full_o, empty_o  out  1  queue status (combinational from state)
- err_o  out  1  sticky protocol error
- br_cnt_o, miss_cnt_o  out  CNT_W  resolved branches / mispredicts

## Operation
- Queue: circular FIFO of {pred, tgt_taken, tgt_ntaken}, with wptr/rptr of log2(DEPTH) bits plus a wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- Push (push_i & ~stall_i): writes the entry at wptr, then advances wptr.
  - A push when full is dropped and sets err_o.
- Resolve (resolve_i & ~stall_i & ~empty): reads the head entry and computes the actual direction from funct3:
  - 000 beq: rs1==rs2
  - 001 bne: rs1!=rs2
  - 100 blt: signed <
  - 101 bge: signed ≥
  - 110 bltu: unsigned <
  - 111 bgeu: unsigned ≥
  - 010/011: not taken, and sets err_o.
- Resolve on empty: no outputs asserted; sets err_o.
- Resolve result, registered:
  - update_o=1 and decision_o=actual.
  - mispredict_o = actual != head.pred.
  - redirect_o = actual ? head.tgt_taken : head.tgt_ntaken.
  - rptr advances.
- Mispredict flush: in the same edge that registers mispredict_o=1, every younger entry is discarded (wptr := rptr+1, i.e. the queue empties).
  - A push in that same cycle is dropped (it is on the wrong path) and does not set err_o.
- Simultaneous push and correct resolve: both take effect; push is legal when full if a resolve pops the same cycle.
- Counters:
  - br_cnt increments on every valid resolve.
  - miss_cnt increments on every mispredict.
  - Both saturate at all-ones and never wrap.
- err_o is cleared only by reset.

## Timing
- Reset values: all pointers 0; empty_o=1, full_o=0; update_o=0, decision_o=0, mispredict_o=0, redirect_o=0; err_o=0; both counters 0.
- Reset asserted mid-operation clears the queue immediately (asynchronously); no pending update is emitted after release.
- Latency: resolve in cycle N produces update_o/decision_o/mispredict_o/redirect_o in cycle N+1.
  - These outputs are 1-cycle pulses and return to 0 in N+2 unless another resolve occurs.
- redirect_o holds its last value when mispredict_o=0.
- Push in cycle N is resolvable from cycle N+1 (no same-cycle bypass). A resolve with an empty queue in that cycle is an error.
- stall_i high freezes the queue and suppresses new output pulses. Pulses already registered still deassert on the next edge.

## Test plan
- Reset, then push pred=1 (T=0x100, NT=0x204), resolve beq with rs1=rs2=5 → next cycle: update_o=1, decision_o=1, mispredict_o=0, br_cnt=1, miss_cnt=0.
- Push pred=1 (T=0x100, NT=0x204), resolve bne with rs1=rs2=7 → mispredict_o=1, redirect_o=0x204, decision_o=0, miss_cnt=1.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1 → blt taken, bltu not taken; bge not taken, bgeu taken.
- Push 2 entries (full_o=1), third push with no resolve → dropped, err_o=1. Then resolve mispredict on the head with a simultaneous push → queue empty, younger entry gone, empty_o=1.
- stall_i=1 with push_i=resolve_i=1 for 3 cycles → no pointer change, no update_o pulse. Release → one resolve processed.
- Drive 2^CNT_W+3 mispredicting resolves (CNT_W=4 build) → br_cnt_o=miss_cnt_o=0xF, no wrap. Assert rst_i mid-run → all outputs zero asynchronously.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Purpose: fetch/EX-facing signal bundle for branch_resolve_unit.
// Latency: wires only; timing is set by the block behind the slave modport.
// Backpressure: none; stall_i freezes the slave, and full_o/empty_o report queue state.
// Ports: stall/push/pred/targets/resolve/funct3/operands in; train, flush, redirect, status and counters out.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             push_i;
  logic             pred_i;
  logic [XLEN-1:0]  tgt_taken_i;
  logic [XLEN-1:0]  tgt_ntaken_i;
  logic             resolve_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic             update_o;
  logic             decision_o;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_o;
  logic             full_o;
  logic             empty_o;
  logic             err_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  modport master (
    output stall_i, push_i, pred_i, tgt_taken_i, tgt_ntaken_i,
           resolve_i, funct3_i, rs1_i, rs2_i,
    input  update_o, decision_o, mispredict_o, redirect_o,
           full_o, empty_o, err_o, br_cnt_o, miss_cnt_o
  );

  modport slave (
    input  stall_i, push_i, pred_i, tgt_taken_i, tgt_ntaken_i,
           resolve_i, funct3_i, rs1_i, rs2_i,
    output update_o, decision_o, mispredict_o, redirect_o,
           full_o, empty_o, err_o, br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose: in-order queue of predicted branches, resolved in EX to train the predictor and flush/redirect on mispredict.
// Latency: resolve in cycle N gives update/decision/mispredict/redirect in N+1; a push is resolvable from N+1.
// Backpressure: push when full (without a same-cycle pop) is dropped and flags err_o; stall_i freezes all queue state.
// Ports: clk_i, rst_i (async, active-low) plus the slave side of branch_resolve_unit_if.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  branch_resolve_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] tgt_taken;
    logic [XLEN-1:0] tgt_ntaken;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             update_q, update_d, decision_q, decision_d;
  logic             mispredict_q, mispredict_d, err_q, err_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic   empty, full, res_ok, actual, bad_f3, miss, push_ok;
  entry_t head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    actual = 1'b0;
    bad_f3 = 1'b0;
    unique case (bus.funct3_i)
      3'b000:  actual = (bus.rs1_i == bus.rs2_i);
      3'b001:  actual = (bus.rs1_i != bus.rs2_i);
      3'b100:  actual = ($signed(bus.rs1_i) <  $signed(bus.rs2_i));
      3'b101:  actual = ($signed(bus.rs1_i) >= $signed(bus.rs2_i));
      3'b110:  actual = (bus.rs1_i <  bus.rs2_i);
      3'b111:  actual = (bus.rs1_i >= bus.rs2_i);
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    res_ok  = bus.resolve_i && !bus.stall_i && !empty;
    miss    = res_ok && (actual != head.pred);
    // A push alongside a mispredict is on the wrong path: silently dropped.
    push_ok = bus.push_i && !bus.stall_i && !miss && (!full || res_ok);

    err_d = err_q;
    if (bus.push_i && !bus.stall_i && !miss && full && !res_ok) err_d = 1'b1;
    if (bus.resolve_i && !bus.stall_i && empty)                 err_d = 1'b1;
    if (res_ok && bad_f3)                                       err_d = 1'b1;

    rptr_d = res_ok ? rptr_q + 1'b1 : rptr_q;
    wptr_d = wptr_q;
    if (miss)         wptr_d = rptr_q + 1'b1;  // flush: queue empties behind the head
    else if (push_ok) wptr_d = wptr_q + 1'b1;

    update_d     = res_ok;
    decision_d   = res_ok && actual;
    mispredict_d = miss;
    redirect_d   = redirect_q;
    if (miss) redirect_d = actual ? head.tgt_taken : head.tgt_ntaken;

    br_cnt_d   = (res_ok && br_cnt_q != '1) ? br_cnt_q + 1'b1 : br_cnt_q;
    miss_cnt_d = (miss && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end

  // Queue storage carries no reset; validity is defined by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= '{pred: bus.pred_i,
                                           tgt_taken: bus.tgt_taken_i,
                                           tgt_ntaken: bus.tgt_ntaken_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      update_q     <= 1'b0;
      decision_q   <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      update_q     <= update_d;
      decision_q   <= decision_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      err_q        <= err_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.update_o     = update_q;
  assign bus.decision_o   = decision_q;
  assign bus.mispredict_o = mispredict_q;
  assign bus.redirect_o   = redirect_q;
  assign bus.full_o       = full;
  assign bus.empty_o      = empty;
  assign bus.err_o        = err_q;
  assign bus.br_cnt_o     = br_cnt_q;
  assign bus.miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose: self-checking bench for branch_resolve_unit against a queue-based reference model.
// Latency: checks sample outputs 1ns after each rising edge.
// Backpressure: exercises full-queue drops, stall freeze and mispredict flush.
module tb_branch_resolve_unit;
  localparam int XLEN = 32, DEPTH = 2, CNT_W = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif();
  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bif)
  );

  typedef struct { logic pred; logic [31:0] tt; logic [31:0] nt; } ment_t;
  ment_t       m_q[$];
  logic        m_upd, m_dec, m_mis, m_err;
  logic [31:0] m_red;
  logic [3:0]  m_br, m_miss;
  int n_chk = 0, n_pass = 0;

  task automatic model_clear();
    m_q.delete(); m_upd = 0; m_dec = 0; m_mis = 0; m_err = 0; m_red = 0; m_br = 0; m_miss = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and land 1ns after the edge.
  task automatic step(input logic st, ps, pr, input logic [31:0] tt, nt,
                      input logic rs, input logic [2:0] f3, input logic [31:0] a, b);
    logic act, ok, mis;
    bif.stall_i = st; bif.push_i = ps; bif.pred_i = pr; bif.tgt_taken_i = tt; bif.tgt_ntaken_i = nt;
    bif.resolve_i = rs; bif.funct3_i = f3; bif.rs1_i = a; bif.rs2_i = b;
    if (st) begin
      m_upd = 0; m_dec = 0; m_mis = 0;
    end else begin
      ok = rs && (m_q.size() > 0);
      if (rs && m_q.size() == 0) m_err = 1;
      case (f3)
        3'd0: act = (a == b);
        3'd1: act = (a != b);
        3'd4: act = ($signed(a) < $signed(b));
        3'd5: act = ($signed(a) >= $signed(b));
        3'd6: act = (a < b);
        3'd7: act = (a >= b);
        default: begin act = 0; if (ok) m_err = 1; end
      endcase
      mis = ok && (act != m_q[0].pred);
      m_upd = ok; m_dec = ok && act; m_mis = mis;
      if (mis) m_red = act ? m_q[0].tt : m_q[0].nt;
      if (ok && m_br != 4'hF) m_br++;
      if (mis && m_miss != 4'hF) m_miss++;
      if (ps && !mis && !(m_q.size() < DEPTH || ok)) m_err = 1;
      if (mis) m_q.delete();
      else begin
        if (ok) void'(m_q.pop_front());
        if (ps && (m_q.size() < DEPTH)) m_q.push_back('{pr, tt, nt});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bif.stall_i = 0; bif.push_i = 0; bif.pred_i = 0; bif.tgt_taken_i = 0; bif.tgt_ntaken_i = 0;
    bif.resolve_i = 0; bif.funct3_i = 0; bif.rs1_i = 0; bif.rs2_i = 0;
    rst_n = 0; model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bif.empty_o !== 1'b1) $display("FAIL reset_empty got %b want 1", bif.empty_o); else n_pass++;
    n_chk++; if (bif.full_o !== 1'b0) $display("FAIL reset_full got %b want 0", bif.full_o); else n_pass++;
    n_chk++; if ({bif.update_o, bif.decision_o, bif.mispredict_o, bif.err_o} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {bif.update_o, bif.decision_o, bif.mispredict_o, bif.err_o}); else n_pass++;
    n_chk++; if (bif.redirect_o !== 32'h0) $display("FAIL reset_redirect got %h want 0", bif.redirect_o); else n_pass++;
    n_chk++; if ({bif.br_cnt_o, bif.miss_cnt_o} !== 8'h0) $display("FAIL reset_cnt got %h want 00", {bif.br_cnt_o, bif.miss_cnt_o}); else n_pass++;
  endtask

  task automatic test_beq_hit();
    step(0, 1, 1, 32'h100, 32'h204, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3'b000, 5, 5);
    n_chk++; if ({bif.update_o, bif.decision_o, bif.mispredict_o} !== 3'b110)
      $display("FAIL beq_flags got %b want 110", {bif.update_o, bif.decision_o, bif.mispredict_o}); else n_pass++;
    n_chk++; if (bif.br_cnt_o !== 4'd1 || bif.miss_cnt_o !== 4'd0)
      $display("FAIL beq_cnt got %0d/%0d want 1/0", bif.br_cnt_o, bif.miss_cnt_o); else n_pass++;
    idle();
    n_chk++; if (bif.update_o !== 1'b0) $display("FAIL beq_pulse got %b want 0", bif.update_o); else n_pass++;
  endtask

  task automatic test_bne_miss();
    step(0, 1, 1, 32'h100, 32'h204, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3'b001, 7, 7);
    n_chk++; if (bif.mispredict_o !== 1'b1 || bif.decision_o !== 1'b0)
      $display("FAIL bne_miss got mis=%b dec=%b want 1 0", bif.mispredict_o, bif.decision_o); else n_pass++;
    n_chk++; if (bif.redirect_o !== 32'h204) $display("FAIL bne_redirect got %h want 00000204", bif.redirect_o); else n_pass++;
    n_chk++; if (bif.miss_cnt_o !== 4'd1) $display("FAIL bne_misscnt got %0d want 1", bif.miss_cnt_o); else n_pass++;
    idle();
    n_chk++; if (bif.mispredict_o !== 1'b0 || bif.redirect_o !== 32'h204)
      $display("FAIL bne_hold got mis=%b red=%h want 0 00000204", bif.mispredict_o, bif.redirect_o); else n_pass++;
  endtask

  task automatic test_signed_unsigned();
    logic [2:0] f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic       want[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'h400 + i, 32'h800 + i, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, f3s[i], 32'hFFFF_FFFF, 32'h1);
      n_chk++; if (bif.decision_o !== want[i] || bif.update_o !== 1'b1)
        $display("FAIL cmp_f3_%0d got dec=%b upd=%b want %b 1", f3s[i], bif.decision_o, bif.update_o, want[i]); else n_pass++;
      n_chk++; if (bif.mispredict_o !== want[i])
        $display("FAIL cmp_mis_%0d got %b want %b", f3s[i], bif.mispredict_o, want[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic ps, rs, st; logic [31:0] a, b;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 99) < 12);
      ps = ($urandom_range(0, 99) < 55);
      rs = ($urandom_range(0, 99) < 50);
      a  = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b  = $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom);
      step(st, ps, 1'($urandom_range(0, 1)), $urandom, $urandom, rs, 3'($urandom_range(0, 7)), a, b);
      n_chk++; if ({bif.update_o, bif.decision_o, bif.mispredict_o} !== {m_upd, m_dec, m_mis})
        $display("FAIL rnd_flags@%0d got %b want %b", i, {bif.update_o, bif.decision_o, bif.mispredict_o}, {m_upd, m_dec, m_mis}); else n_pass++;
      n_chk++; if (bif.redirect_o !== m_red) $display("FAIL rnd_redirect@%0d got %h want %h", i, bif.redirect_o, m_red); else n_pass++;
      n_chk++; if ({bif.empty_o, bif.full_o} !== {m_q.size() == 0, m_q.size() == DEPTH})
        $display("FAIL rnd_status@%0d got %b want %b", i, {bif.empty_o, bif.full_o}, {m_q.size() == 0, m_q.size() == DEPTH}); else n_pass++;
      n_chk++; if (bif.err_o !== m_err) $display("FAIL rnd_err@%0d got %b want %b", i, bif.err_o, m_err); else n_pass++;
      n_chk++; if ({bif.br_cnt_o, bif.miss_cnt_o} !== {m_br, m_miss})
        $display("FAIL rnd_cnt@%0d got %h want %h", i, {bif.br_cnt_o, bif.miss_cnt_o}, {m_br, m_miss}); else n_pass++;
    end
  endtask

  task automatic test_full_drop();
    step(0, 1, 0, 32'hA00, 32'hA04, 0, 0, 0, 0);
    step(0, 1, 1, 32'hB00, 32'hB04, 0, 0, 0, 0);
    n_chk++; if (bif.full_o !== 1'b1 || bif.err_o !== 1'b0)
      $display("FAIL full_set got full=%b err=%b want 1 0", bif.full_o, bif.err_o); else n_pass++;
    step(0, 1, 1, 32'hC00, 32'hC04, 0, 0, 0, 0);
    n_chk++; if (bif.err_o !== 1'b1 || bif.full_o !== 1'b1)
      $display("FAIL full_drop got err=%b full=%b want 1 1", bif.err_o, bif.full_o); else n_pass++;
    step(0, 1, 1, 32'hD00, 32'hD04, 1, 3'b001, 1, 2);
    n_chk++; if (bif.mispredict_o !== 1'b1 || bif.redirect_o !== 32'hA00)
      $display("FAIL flush_miss got mis=%b red=%h want 1 00000a00", bif.mispredict_o, bif.redirect_o); else n_pass++;
    n_chk++; if (bif.empty_o !== 1'b1 || bif.full_o !== 1'b0)
      $display("FAIL flush_empty got empty=%b full=%b want 1 0", bif.empty_o, bif.full_o); else n_pass++;
    step(0, 0, 0, 0, 0, 1, 3'b000, 0, 0);
    n_chk++; if (bif.update_o !== 1'b0) $display("FAIL flush_gone got upd=%b want 0", bif.update_o); else n_pass++;
  endtask

  task automatic test_stall();
    step(0, 1, 1, 32'h300, 32'h304, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'h500, 32'h504, 1, 3'b000, 0, 0);
      n_chk++; if (bif.update_o !== 1'b0 || bif.empty_o !== 1'b0 || bif.full_o !== 1'b0)
        $display("FAIL stall_%0d got upd=%b empty=%b full=%b want 0 0 0", i, bif.update_o, bif.empty_o, bif.full_o); else n_pass++;
    end
    step(0, 0, 0, 0, 0, 1, 3'b000, 9, 9);
    n_chk++; if ({bif.update_o, bif.decision_o, bif.mispredict_o, bif.empty_o} !== 4'b1101)
      $display("FAIL stall_release got %b want 1101", {bif.update_o, bif.decision_o, bif.mispredict_o, bif.empty_o}); else n_pass++;
    n_chk++; if (bif.br_cnt_o !== m_br) $display("FAIL stall_cnt got %0d want %0d", bif.br_cnt_o, m_br); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      step(0, 1, 1, 32'h600, 32'h604, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3'b001, 7, 7);
      n_chk++; if (bif.mispredict_o !== 1'b1 || bif.miss_cnt_o !== m_miss)
        $display("FAIL sat_%0d got mis=%b cnt=%0d want 1 %0d", i, bif.mispredict_o, bif.miss_cnt_o, m_miss); else n_pass++;
    end
    n_chk++; if (bif.br_cnt_o !== 4'hF || bif.miss_cnt_o !== 4'hF)
      $display("FAIL sat_final got %h/%h want f/f", bif.br_cnt_o, bif.miss_cnt_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(0, 1, 1, 32'h700, 32'h704, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    n_chk++; if ({bif.update_o, bif.mispredict_o, bif.err_o, bif.empty_o, bif.full_o} !== 5'b00010)
      $display("FAIL arst_flags got %b want 00010", {bif.update_o, bif.mispredict_o, bif.err_o, bif.empty_o, bif.full_o}); else n_pass++;
    n_chk++; if ({bif.br_cnt_o, bif.miss_cnt_o} !== 8'h0 || bif.redirect_o !== 32'h0)
      $display("FAIL arst_regs got cnt=%h red=%h want 00 0", {bif.br_cnt_o, bif.miss_cnt_o}, bif.redirect_o); else n_pass++;
    model_clear();
    bif.push_i = 0; bif.resolve_i = 0;
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    idle();
    n_chk++; if (bif.update_o !== 1'b0 || bif.empty_o !== 1'b1)
      $display("FAIL arst_release got upd=%b empty=%b want 0 1", bif.update_o, bif.empty_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_beq_hit();
    test_bne_miss();
    test_signed_unsigned();
    test_random();
    do_reset();
    test_full_drop();
    test_stall();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
